// File: rtl/game_pkg.sv
// Shared scene encoding and pixel-width helper for the game display path.
package game_pkg;

    typedef enum logic [1:0] {
        StTitle  = 2'd0,
        StPlay   = 2'd1,
        StPaused = 2'd2,
        StOver   = 2'd3
    } scene_e;

    // Width of one packed R,G,B pixel for a given channel width.
    function automatic int unsigned rgb_width(input int unsigned color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/scene_pixel_mux.sv
// Combinational pixel path: picks the source for the scene, then applies dim and blink.
module scene_pixel_mux
    import game_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned COLOR_W = 4
) (
    input  scene_e                                   state,
    input  logic                                     video_on,
    input  logic                                     blink,
    input  logic [NUM_SRC*rgb_width(COLOR_W)-1:0]    src_rgb,
    output logic [rgb_width(COLOR_W)-1:0]            rgb_next
);

    localparam int unsigned PixW    = rgb_width(COLOR_W);
    localparam int unsigned OverSrc = (NUM_SRC > 2) ? 2 : 1;

    logic [PixW-1:0]    src_sel;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

    always_comb begin
        case (state)
            StTitle:          src_sel = src_rgb[0 +: PixW];
            StPlay, StPaused: src_sel = src_rgb[PixW +: PixW];
            default:          src_sel = src_rgb[OverSrc*PixW +: PixW];
        endcase
    end

    assign {red, green, blue} = src_sel;

    always_comb begin
        rgb_next = src_sel;
        if (!video_on) begin
            rgb_next = '0;
        end else if (state == StPaused) begin
            rgb_next = {red >> 1, green >> 1, blue >> 1};
        end else if ((state == StOver) && blink) begin
            rgb_next = '0;
        end
    end

endmodule

// File: rtl/scene_sequencer.sv
// Game scene FSM with frame/hold counters and the registered pixel output stage.
module scene_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned FRAME_W     = 8,
    parameter int unsigned FRAME_Y     = 481,
    parameter int unsigned HOLD_FRAMES = 120,
    parameter int unsigned BLINK_BIT   = 4
) (
    input  logic                                  clk_100MHz,
    input  logic                                  reset,
    input  logic                                  p_tick,
    input  logic                                  video_on,
    input  logic [9:0]                            x,
    input  logic [9:0]                            y,
    input  logic                                  game_start,
    input  logic                                  pause,
    input  logic                                  game_over,
    input  logic [NUM_SRC*rgb_width(COLOR_W)-1:0] src_rgb,
    output logic [rgb_width(COLOR_W)-1:0]         rgb,
    output logic                                  game_freeze,
    output logic [1:0]                            scene,
    output logic [FRAME_W-1:0]                    frame_cnt
);

    localparam int unsigned PixW  = rgb_width(COLOR_W);
    localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

    scene_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [PixW-1:0]    rgb_q, rgb_d;
    logic [PixW-1:0]    rgb_next;
    logic               frame_tick;

    assign frame_tick = p_tick && (y == 10'(FRAME_Y)) && (x == 10'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTitle: begin
                if (game_start) state_d = StPlay;
            end
            StPlay: begin
                if (!game_start)    state_d = StTitle;
                else if (game_over) state_d = StOver;
                else if (pause)     state_d = StPaused;
            end
            StPaused: begin
                if (!game_start) state_d = StTitle;
                else if (!pause) state_d = StPlay;
            end
            StOver: begin
                if ((hold_cnt_q == HoldMax) && !game_start) state_d = StTitle;
            end
            default: state_d = StTitle;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) frame_cnt_d = frame_cnt_q + 1'b1;
    end

    // Held at zero outside OVER, so it always starts from 0 on entry.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_q != StOver) begin
            hold_cnt_d = '0;
        end else if (frame_tick && (hold_cnt_q != HoldMax)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    scene_pixel_mux #(
        .NUM_SRC (NUM_SRC),
        .COLOR_W (COLOR_W)
    ) u_pixel_mux (
        .state    (state_q),
        .video_on (video_on),
        .blink    (frame_cnt_q[BLINK_BIT]),
        .src_rgb  (src_rgb),
        .rgb_next (rgb_next)
    );

    // rgb_next comes from state_q, so a same-clock transition uses the old scene.
    always_comb begin
        rgb_d = rgb_q;
        if (p_tick) rgb_d = rgb_next;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= StTitle;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb         = rgb_q;
    assign game_freeze = (state_q != StPlay);
    assign scene       = state_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: directed scenarios plus random traffic vs a model.
module tb_scene_sequencer;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        p_tick     = 1'b0;
    logic        video_on   = 1'b0;
    logic [9:0]  x          = '0;
    logic [9:0]  y          = '0;
    logic        game_start = 1'b0;
    logic        pause      = 1'b0;
    logic        game_over  = 1'b0;
    logic [35:0] src_rgb    = '0;
    logic [11:0] rgb;
    logic        game_freeze;
    logic [1:0]  scene;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: scene number, frames, frames spent in OVER, output pixel.
    int          m_state = 0;
    int          m_frame = 0;
    int          m_hold  = 0;
    logic [11:0] m_rgb   = '0;

    scene_sequencer dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .p_tick      (p_tick),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .game_start  (game_start),
        .pause       (pause),
        .game_over   (game_over),
        .src_rgb     (src_rgb),
        .rgb         (rgb),
        .game_freeze (game_freeze),
        .scene       (scene),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [11:0] model_pix(input int st, input int frame, input logic vid,
                                              input logic [35:0] src);
        int          idx;
        logic [11:0] s;
        int          r, g, b;
        if (!vid) return 12'h000;
        idx = (st == 0) ? 0 : ((st == 3) ? 2 : 1);
        s   = src[idx*12 +: 12];
        r   = int'(s[11:8]);
        g   = int'(s[7:4]);
        b   = int'(s[3:0]);
        if (st == 2) begin
            r = r / 2;
            g = g / 2;
            b = b / 2;
        end
        if (st == 3 && ((frame / 16) % 2 == 1)) return 12'h000;
        return 12'(r * 256 + g * 16 + b);
    endfunction

    // Advance the model from the current inputs, then clock the DUT and settle.
    task automatic cycle();
        bit ft;
        int ns;
        ft = p_tick && (y == 10'd481) && (x == 10'd0);
        if (reset) begin
            m_state = 0;
            m_frame = 0;
            m_hold  = 0;
            m_rgb   = '0;
        end else begin
            if (p_tick) m_rgb = model_pix(m_state, m_frame, video_on, src_rgb);
            ns = m_state;
            case (m_state)
                0: if (game_start) ns = 1;
                1: begin
                    if (!game_start)    ns = 0;
                    else if (game_over) ns = 3;
                    else if (pause)     ns = 2;
                end
                2: begin
                    if (!game_start) ns = 0;
                    else if (!pause) ns = 1;
                end
                default: if (m_hold == 120 && !game_start) ns = 0;
            endcase
            if (m_state != 3)                 m_hold = 0;
            else if (ft && m_hold < 120)      m_hold = m_hold + 1;
            m_frame = (m_frame + (ft ? 1 : 0)) % 256;
            m_state = ns;
        end
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_frame_tick(input bit on);
        p_tick = 1'b1;
        x      = on ? 10'd0 : 10'd17;
        y      = on ? 10'd481 : 10'd100;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        n_checks++;
        if (scene !== 2'd0) begin
            n_errors++; $display("FAIL reset_scene got %0d want 0", scene);
        end
        n_checks++;
        if (game_freeze !== 1'b1) begin
            n_errors++; $display("FAIL reset_freeze got %b want 1", game_freeze);
        end
        n_checks++;
        if (rgb !== 12'h000 || frame_cnt !== 8'd0) begin
            n_errors++; $display("FAIL reset_regs got rgb=%h frame=%0d want 0/0", rgb, frame_cnt);
        end
    endtask

    task automatic test_start();
        logic [11:0] s1;
        game_start = 1'b1;
        p_tick     = 1'b0;
        cycle();
        n_checks++;
        if (scene !== 2'd1 || game_freeze !== 1'b0) begin
            n_errors++; $display("FAIL start_scene got %0d/%b want 1/0", scene, game_freeze);
        end
        s1       = 12'($urandom);
        src_rgb  = {12'($urandom), s1, 12'($urandom)};
        video_on = 1'b1;
        set_frame_tick(1'b0);
        cycle();
        p_tick = 1'b0;
        n_checks++;
        if (rgb !== s1 || rgb !== m_rgb) begin
            n_errors++; $display("FAIL start_rgb got %h want %h", rgb, s1);
        end
    endtask

    task automatic test_pause();
        src_rgb[23:12] = 12'hFFF;
        pause = 1'b1;
        set_frame_tick(1'b0);
        cycle();
        n_checks++;
        if (scene !== 2'd2 || rgb !== 12'hFFF) begin
            n_errors++; $display("FAIL pause_same_clock got scene=%0d rgb=%h want 2/fff", scene, rgb);
        end
        cycle();
        n_checks++;
        if (rgb !== 12'h777) begin
            n_errors++; $display("FAIL pause_dim got %h want 777", rgb);
        end
        pause  = 1'b0;
        p_tick = 1'b0;
        cycle();
        n_checks++;
        if (scene !== 2'd1 || rgb !== 12'h777) begin
            n_errors++; $display("FAIL unpause_hold got scene=%0d rgb=%h want 1/777", scene, rgb);
        end
        set_frame_tick(1'b0);
        cycle();
        p_tick = 1'b0;
        n_checks++;
        if (rgb !== 12'hFFF) begin
            n_errors++; $display("FAIL unpause_rgb got %h want fff", rgb);
        end
    endtask

    task automatic test_over_hold();
        int bad_scene;
        int bad_rgb;
        int n_on;
        int n_off;
        game_over = 1'b1;
        pause     = 1'b1;
        p_tick    = 1'b0;
        cycle();
        n_checks++;
        if (scene !== 2'd3) begin
            n_errors++; $display("FAIL over_entry got %0d want 3", scene);
        end
        game_over      = 1'b0;
        pause          = 1'b0;
        game_start     = 1'b0;
        video_on       = 1'b1;
        src_rgb[35:24] = 12'hF00;
        bad_scene = 0;
        bad_rgb   = 0;
        n_on      = 0;
        n_off     = 0;
        for (int i = 0; i < 120; i++) begin
            set_frame_tick(1'b1);
            cycle();
            if (scene !== 2'd3) bad_scene++;
            if (rgb !== m_rgb) bad_rgb++;
            if (rgb === 12'hF00) n_on++;
            if (rgb === 12'h000) n_off++;
        end
        n_checks++;
        if (bad_scene != 0) begin
            n_errors++; $display("FAIL over_hold left early count=%0d want 0", bad_scene);
        end
        n_checks++;
        if (bad_rgb != 0 || n_on + n_off != 120 || n_on < 48 || n_off < 48) begin
            n_errors++;
            $display("FAIL over_blink bad=%0d on=%0d off=%0d want 0 and both >=48",
                     bad_rgb, n_on, n_off);
        end
        p_tick = 1'b0;
        cycle();
        n_checks++;
        if (scene !== 2'd0) begin
            n_errors++; $display("FAIL over_exit got %0d want 0", scene);
        end
    endtask

    task automatic test_video_off();
        int bad;
        bad      = 0;
        video_on = 1'b0;
        for (int i = 0; i < 12; i++) begin
            src_rgb    = {4'($urandom), 32'($urandom)};
            game_start = 1'($urandom);
            pause      = 1'($urandom);
            set_frame_tick(1'b0);
            cycle();
            if (rgb !== 12'h000) bad++;
        end
        p_tick = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL video_off nonzero count=%0d want 0", bad);
        end
        game_start = 1'b0;
        pause      = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_frame_wrap();
        int guard;
        guard = 0;
        while (m_frame != 255 && guard < 300) begin
            set_frame_tick(1'b1);
            cycle();
            guard++;
        end
        n_checks++;
        if (frame_cnt !== 8'd255) begin
            n_errors++; $display("FAIL frame_top got %0d want 255", frame_cnt);
        end
        cycle();
        p_tick = 1'b0;
        n_checks++;
        if (frame_cnt !== 8'd0) begin
            n_errors++; $display("FAIL frame_wrap got %0d want 0", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_over();
        game_start = 1'b1;
        p_tick     = 1'b0;
        cycle();
        game_over = 1'b1;
        cycle();
        game_over = 1'b0;
        for (int i = 0; i < 50; i++) begin
            set_frame_tick(1'b1);
            cycle();
        end
        n_checks++;
        if (scene !== 2'd3 || frame_cnt !== 8'(m_frame)) begin
            n_errors++;
            $display("FAIL over_before_reset got %0d/%0d want 3/%0d", scene, frame_cnt, m_frame);
        end
        video_on = 1'b1;
        src_rgb  = 36'hFFF_FFF_FFF;
        reset    = 1'b1;
        set_frame_tick(1'b1);
        cycle();
        reset  = 1'b0;
        p_tick = 1'b0;
        n_checks++;
        if (scene !== 2'd0 || game_freeze !== 1'b1 || frame_cnt !== 8'd0 || rgb !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_mid_over got scene=%0d frz=%b frame=%0d rgb=%h want 0/1/0/000",
                     scene, game_freeze, frame_cnt, rgb);
        end
    endtask

    task automatic test_random();
        int bad_scene, bad_frz, bad_rgb, bad_frame;
        bad_scene = 0;
        bad_frz   = 0;
        bad_rgb   = 0;
        bad_frame = 0;
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            game_start = ($urandom_range(0, 19) != 0);
            pause      = ($urandom_range(0, 3) == 0);
            game_over  = ($urandom_range(0, 15) == 0);
            video_on   = ($urandom_range(0, 3) != 0);
            src_rgb    = {4'($urandom), 32'($urandom)};
            p_tick     = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                x = 10'd0;
                y = 10'd481;
            end else begin
                x = 10'($urandom_range(0, 799));
                y = 10'($urandom_range(0, 524));
            end
            cycle();
            if (scene !== 2'(m_state)) bad_scene++;
            if (game_freeze !== (m_state != 1)) bad_frz++;
            if (rgb !== m_rgb) bad_rgb++;
            if (frame_cnt !== 8'(m_frame)) bad_frame++;
        end
        reset = 1'b0;
        n_checks++;
        if (bad_scene != 0) begin
            n_errors++; $display("FAIL random_scene mismatches=%0d want 0", bad_scene);
        end
        n_checks++;
        if (bad_frz != 0) begin
            n_errors++; $display("FAIL random_freeze mismatches=%0d want 0", bad_frz);
        end
        n_checks++;
        if (bad_rgb != 0) begin
            n_errors++; $display("FAIL random_rgb mismatches=%0d want 0", bad_rgb);
        end
        n_checks++;
        if (bad_frame != 0) begin
            n_errors++; $display("FAIL random_frame mismatches=%0d want 0", bad_frame);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_over_hold();
        test_video_off();
        test_frame_wrap();
        test_reset_mid_over();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_SRC, default 3, number of RGB sources, minimum 2; COLOR_W, default 4, bits per colour channel; FRAME_W, default 8, frame counter width; FRAME_Y, default 481, scan line that marks end of frame; HOLD_FRAMES, default 120, minimum frames spent in OVER; BLINK_BIT, default 4, frame_cnt bit that drives the OVER blink.
REQ-002 clk_100MHz  in  1  system clock; the only clock in the block.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 p_tick  in  1  pixel strobe from the VGA controller.
REQ-005 video_on  in  1  high while the pixel is in the active area.
REQ-006 x, y  in  10 each  current pixel coordinates.
REQ-007 game_start, pause, game_over  in  1 each  start switch level, pause switch level, game-over pulse or level.
REQ-008 src_rgb  in  NUM_SRC*3*COLOR_W  concatenated source pixels; source k occupies slice k; within each source the order is R, G, B from MSB to LSB.
REQ-009 rgb  out  3*COLOR_W  registered pixel to the pins.
REQ-010 game_freeze  out  1  high whenever state is not PLAY.
REQ-011 scene  out  2  current state encoding.
REQ-012 frame_cnt  out  FRAME_W  free-running frame counter.

Function
REQ-013 frame_tick SHALL be asserted for exactly one clock when p_tick=1, y=FRAME_Y and x=0.
REQ-014 frame_cnt SHALL increment by one on each frame_tick and wrap from all-ones to 0.
REQ-015 States SHALL be TITLE=0, PLAY=1, PAUSED=2, OVER=3, and transitions SHALL be evaluated on every clock.
REQ-016 In TITLE, the state SHALL move to PLAY when game_start=1.
REQ-017 In PLAY, transition priority SHALL be: game_start=0 goes to TITLE; otherwise game_over=1 goes to OVER; otherwise pause=1 goes to PAUSED.
REQ-018 In PAUSED, game_start=0 SHALL go to TITLE; otherwise pause=0 SHALL go to PLAY; game_over SHALL be ignored in PAUSED.
REQ-019 On entry to OVER, hold_cnt SHALL load 0, then increment on each frame_tick and saturate at HOLD_FRAMES.
REQ-020 OVER SHALL go to TITLE only when hold_cnt=HOLD_FRAMES and game_start=0; otherwise it SHALL stay in OVER.
REQ-021 Source selection SHALL be: TITLE uses source 0; PLAY and PAUSED use source 1; OVER uses source 2 if NUM_SRC>2, else source 1.
REQ-022 In PAUSED, each colour channel of the selected source SHALL be logically right-shifted by 1 (dimmed).
REQ-023 In OVER, when frame_cnt[BLINK_BIT]=1, the pixel SHALL be forced to 0 (blink).
REQ-024 When video_on=0, rgb_next SHALL be 0 regardless of state.
REQ-025 rgb SHALL update only on clocks where p_tick=1, taking rgb_next computed from the current state and src_rgb; latency is one p_tick.
REQ-026 rgb SHALL hold its value between p_ticks.
REQ-027 game_freeze and scene SHALL be driven directly from the state register, with no extra latency.
REQ-028 A state change and a p_tick in the same clock SHALL cause rgb to use the pre-transition state.

Reset
REQ-029 While reset=1 on a clock edge: state SHALL become TITLE, and frame_cnt, hold_cnt and rgb SHALL become 0.
REQ-030 Reset SHALL take priority over every other event, including frame_tick and p_tick, and SHALL abort OVER mid-hold.
REQ-031 After reset, game_freeze SHALL be 1 and scene SHALL be 0.

Structure
REQ-032 The state encoding constants and the RGB slice-width helper SHALL live in a shared package, game_pkg.
REQ-033 Pixel select/dim/blink SHALL be a combinational sub-module, scene_pixel_mux; the FSM, counters and output register SHALL remain in scene_sequencer.
REQ-034 The block SHALL replace the inline title/game multiplexer and frame counter in the VGA top level.

Verification
REQ-035 Reset, then game_start=1 held -> scene=1 on the next clock, game_freeze=0, and rgb=src 1 on the following p_tick.
REQ-036 In PLAY, assert pause=1 with src1=12'hFFF -> scene=2 and rgb=12'h777; release pause -> scene=1 and rgb=12'hFFF.
REQ-037 In PLAY, game_over and pause asserted in the same clock -> scene=3; with game_start dropped, the state stays OVER for 120 frame_ticks, then goes to TITLE on the next clock.
REQ-038 In OVER with src2=12'hF00 -> rgb alternates between 12'hF00 and 0 every 16 frames.
REQ-039 Drive video_on=0 with any source value -> rgb=0; frame_cnt at 255 plus one frame_tick -> 0.
REQ-040 Assert reset mid-OVER with hold_cnt=50 -> next clock: scene=0, frame_cnt=0, rgb=0.
